// File: rtl/data_memory_responder.sv
// Word-organised data RAM answering LSU load/store requests after a fixed LATENCY.
// Optional DMEM_ERROR_EN adds a memory_error pulse for out-of-range accesses (default: addresses wrap).
module data_memory_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_require,
    input  logic        memory_write_enable,
    input  logic [3:0]  memory_bytes_enable_map,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        memory_ready
`ifdef DMEM_ERROR_EN
    ,
    output logic        memory_error
`endif
);
    localparam int          IDX_W = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         count;
    logic               we_q;
    logic [3:0]         map_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               acc_we;
    logic [3:0]         acc_map;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [31:0]        acc_off;
    logic [IDX_W-1:0]   acc_idx;
    logic               acc_ok;
    logic               enter_resp;

    // With LATENCY = 1 the access completes on the sampling edge, so the live inputs are used.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = memory_write_enable;
            acc_map   = memory_bytes_enable_map;
            acc_addr  = memory_address;
            acc_wdata = memory_write_data;
        end else begin
            acc_we    = we_q;
            acc_map   = map_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_idx = IDX_W'(acc_off >> 2);
`ifdef DMEM_ERROR_EN
        acc_ok  = (acc_addr >= BASE_ADDR) && ({1'b0, acc_off} < SPAN);
`else
        acc_ok  = 1'b1;
`endif
        enter_resp = reset &&
                     (((state == IDLE) && memory_require && (LATENCY == 1)) ||
                      ((state == WAIT) && (count == 4'd1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            count            <= 4'd0;
            memory_ready     <= 1'b0;
            memory_read_data <= 32'h0;
`ifdef DMEM_ERROR_EN
            memory_error     <= 1'b0;
`endif
        end else begin
            memory_ready <= enter_resp;
`ifdef DMEM_ERROR_EN
            memory_error <= enter_resp && !acc_ok;
`endif
            if (enter_resp && !acc_we)
                memory_read_data <= acc_ok ? mem[acc_idx] : 32'h0;
            case (state)
                IDLE: begin
                    if (memory_require) begin
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1)
                        state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture and RAM array are data, so they carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && memory_require) begin
            we_q    <= memory_write_enable;
            map_q   <= memory_bytes_enable_map;
            addr_q  <= memory_address;
            wdata_q <= memory_write_data;
        end
        if (enter_resp && acc_we && acc_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_map[i])
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder against an array-based memory model.
// Build with DMEM_ERROR_EN defined to exercise the memory_error port.
module tb_data_memory_responder;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  map = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready;
`ifdef DMEM_ERROR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    logic [31:0] last_rd = 32'h0;
    bit          last_rd_known = 1'b1;
    logic [31:0] last_obs;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .memory_require          (req),
        .memory_write_enable     (wen),
        .memory_bytes_enable_map (map),
        .memory_address          (addr),
        .memory_write_data       (wdata),
        .memory_read_data        (rdata),
        .memory_ready            (ready)
`ifdef DMEM_ERROR_EN
        ,
        .memory_error            (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_ERROR_EN
        return (a < BASE) || ({1'b0, a} >= {1'b0, BASE} + 33'(DEPTH) * 4);
`else
        return 1'b0;
`endif
    endfunction

    // One complete access: latency, returned data, error flag and single-cycle pulse width.
    task automatic access(input logic we, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int  n = 0;
        bit  got = 0;
        bit  oor;
        int  idx;
        logic [31:0] exp;
        @(negedge clk);
        req = 1'b1; wen = we; map = m; addr = a; wdata = wd;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ready) got = 1;
        end
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        oor = out_of_range(a);
        idx = int'(((a - BASE) >> 2) % DEPTH);
        if (got) begin
            last_obs = rdata;
            if (!we) begin
                exp = oor ? 32'h0 : model[idx];
                if (oor || known[idx]) begin
                    chk({tag, "_rd"}, rdata, exp);
                    last_rd = exp; last_rd_known = 1'b1;
                end else begin
                    last_rd_known = 1'b0;
                end
            end else begin
                if (last_rd_known) chk({tag, "_rd_hold"}, rdata, last_rd);
                if (!oor) begin
                    for (int i = 0; i < 4; i++)
                        if (m[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
                    if (m == 4'hF) known[idx] = 1'b1;
                end
            end
`ifdef DMEM_ERROR_EN
            chk({tag, "_err"}, 32'(err), 32'(oor));
`endif
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(ready), 32'h0);
    endtask

    initial begin
        int t_ready [$];
        int cyc;
        #1;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int w = 0; w < 64; w++)
            access(1'b1, 4'hF, BASE + 32'(w * 4), $urandom, "init");

        // Basic store then load
        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "st10");
        access(1'b0, 4'h0, 32'h10, 32'h0, "ld10");
        chk("ld10_const", last_obs, 32'hDEADBEEF);

        // Async reset clears outputs immediately, then no spurious pulses
        @(negedge clk); #2;
        reset = 1'b0; #1;
        chk("arst_ready", 32'(ready), 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        repeat (3) begin @(posedge clk); #1; if (ready) cyc++; end
        chk("idle_no_ready", 32'(cyc), 32'h0);

        // Byte lanes
        access(1'b1, 4'hF, 32'h20, 32'h11223344, "st20");
        access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, "st20_lanes");
        access(1'b0, 4'h0, 32'h22, 32'h0, "ld22");
        chk("lanes_const", last_obs, 32'h11BB33DD);
        access(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, "st20_nomap");
        access(1'b0, 4'h0, 32'h20, 32'h0, "ld20");

        // Back-to-back loads with request held high
        @(negedge clk);
        req = 1'b1; wen = 1'b0; map = 4'h0; addr = 32'h10;
        cyc = 0;
        while (t_ready.size() < 3 && cyc < 30) begin
            @(posedge clk); #1; cyc++;
            if (ready) begin
                t_ready.push_back(cyc);
                chk("b2b_rd", rdata, model[t_ready.size() == 1 ? 4 : (t_ready.size() == 2 ? 8 : 12)]);
                @(negedge clk);
                if (t_ready.size() == 1) addr = 32'h20;
                else if (t_ready.size() == 2) addr = 32'h30;
                else req = 1'b0;
            end
        end
        chk("b2b_count", 32'(t_ready.size()), 32'd3);
        if (t_ready.size() == 3) begin
            chk("b2b_gap1", 32'(t_ready[1] - t_ready[0]), 32'(LAT + 1));
            chk("b2b_gap2", 32'(t_ready[2] - t_ready[1]), 32'(LAT + 1));
        end
        req = 1'b0;
        repeat (2) @(posedge clk);
        last_rd = model[12];

        // Abort a store by reset while it waits
        access(1'b1, 4'hF, 32'h30, 32'hCAFEF00D, "st30");
        @(negedge clk);
        req = 1'b1; wen = 1'b1; map = 4'hF; addr = 32'h30; wdata = 32'h0;
        @(posedge clk); #2;
        reset = 1'b0;
        req = 1'b0;
        cyc = 0;
        repeat (3) begin @(posedge clk); #1; if (ready) cyc++; end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (ready) cyc++; end
        chk("abort_no_ready", 32'(cyc), 32'h0);
        last_rd = 32'h0;
        access(1'b0, 4'h0, 32'h30, 32'h0, "ld30");
        chk("abort_const", last_obs, 32'hCAFEF00D);

        // Out-of-range load
        access(1'b0, 4'h0, 32'h1000, 32'h0, "ld1000");
`ifdef DMEM_ERROR_EN
        chk("oor_const", last_obs, 32'h0);
`else
        chk("wrap_const", last_obs, model[0]);
`endif

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            logic [31:0] ra;
            ra = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = ra + 32'(DEPTH * 4);
            access(1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom, "rnd");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
